// File: rtl/adc_scan_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer_pkg
// Shared definitions for the ADC scan sequencer: USB command codes, widths,
// the scan state encoding and the FIFO word packing helper.
// No ports (package).
// ---------------------------------------------------------------------------
package adc_scan_sequencer_pkg;

    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int DATA_W   = 12;
    localparam int CMD_W    = 16;
    localparam int FIFO_W   = 16;
    localparam int SETTLE_W = 8;

    localparam logic [CMD_W-1:0] CMD_ACQ_START  = 16'hF0F0;
    localparam logic [CMD_W-1:0] CMD_ACQ_STOP   = 16'hF0F1;
    localparam logic [11:0]      CMD_CH_MASK_HI = 12'hC00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CONVERT = 3'd2,
        ST_WAIT    = 3'd3,
        ST_WRITE   = 3'd4,
        ST_NEXT    = 3'd5
    } scan_state_t;

    // FIFO word layout: channel tag in the top bits, zero pad, then the sample.
    function automatic logic [FIFO_W-1:0] pack_fifo_word(
        input logic [CH_W-1:0]   ch,
        input logic [DATA_W-1:0] sample
    );
        return {ch, {(FIFO_W-CH_W-DATA_W){1'b0}}, sample};
    endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer_if
// Bundles the command input, ADC handshake, USB data FIFO write port and
// status outputs of the scan sequencer.
//   master : sequencer side (drives mux select, conv start, FIFO write, status)
//   slave  : environment side (command decoder, ADC front end, FIFO)
// ---------------------------------------------------------------------------
interface adc_scan_sequencer_if;
    import adc_scan_sequencer_pkg::*;

    logic                cmd_valid;
    logic [CMD_W-1:0]    cmd_word;
    logic [CH_W-1:0]     adc_chn_select;
    logic                adc_conv_start;
    logic                adc_data_valid;
    logic [DATA_W-1:0]   adc_data;
    logic                fifo_wr_en;
    logic [FIFO_W-1:0]   fifo_din;
    logic                fifo_full;
    logic                acq_busy;
    logic                overflow;

    modport master (
        input  cmd_valid, cmd_word, adc_data_valid, adc_data, fifo_full,
        output adc_chn_select, adc_conv_start, fifo_wr_en, fifo_din,
               acq_busy, overflow
    );

    modport slave (
        output cmd_valid, cmd_word, adc_data_valid, adc_data, fifo_full,
        input  adc_chn_select, adc_conv_start, fifo_wr_en, fifo_din,
               acq_busy, overflow
    );

endinterface

// File: rtl/adc_scan_sequencer_rr_next_channel.sv
// ---------------------------------------------------------------------------
// rr_next_channel
// Combinational round-robin pick: returns the first enabled channel strictly
// after cur_ch (wrapping), falling back to cur_ch itself when it is the only
// enabled one. Feeding cur_ch = NUM_CH-1 yields the first enabled channel
// counting from 0.
//   mask        in  NUM_CH  channel enable mask
//   cur_ch      in  CH_W    current channel
//   next_ch     out CH_W    next enabled channel (cur_ch if none)
//   any_enabled out 1       mask is non-zero
// ---------------------------------------------------------------------------
module rr_next_channel
    import adc_scan_sequencer_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur_ch,
    output logic [CH_W-1:0]   next_ch,
    output logic              any_enabled
);

    logic [CH_W-1:0] cand_s;

    // Scan candidates farthest-first so the nearest enabled one wins last;
    // offset NUM_CH wraps back onto cur_ch and has the lowest priority.
    always_comb begin
        next_ch     = cur_ch;
        cand_s      = cur_ch;
        any_enabled = |mask;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand_s  = cur_ch + CH_W'(k);
            next_ch = mask[cand_s] ? cand_s : next_ch;
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer
// Sequences the ADC mux and conversion handshake for continuous round-robin
// acquisition over the enabled channels and writes tagged samples into the
// USB data FIFO. A full FIFO drops the sample and sets the sticky overflow.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   bus      master modport of adc_scan_sequencer_if (command, ADC, FIFO,
//            acq_busy, overflow)
// Optional feature macro: ADC_SCAN_TIMEOUT_EN -- abandon a conversion after
// TIMEOUT_CYCLES in WAIT, flag overflow and move to the next channel.
// Without it WAIT blocks until the ADC answers (only reset leaves a hung ADC).
// ---------------------------------------------------------------------------
module adc_scan_sequencer
    import adc_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8
`ifdef ADC_SCAN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
)
(
    input  logic clk,
    input  logic reset_n,
    adc_scan_sequencer_if.master bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

`ifdef ADC_SCAN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wait_cnt_r;
`else
    // WAIT has no cycle budget in this build.
`endif

    scan_state_t         state_r;
    logic [NUM_CH-1:0]   ch_mask_r;
    logic                stop_pending_r;
    logic [CH_W-1:0]     cur_ch_r;
    logic [SETTLE_W-1:0] settle_cnt_r;

    logic [CH_W-1:0]     adc_chn_select_r;
    logic                adc_conv_start_r;
    logic                fifo_wr_en_r;
    logic [FIFO_W-1:0]   fifo_din_r;
    logic                acq_busy_r;
    logic                overflow_r;

    logic                is_start_s;
    logic                is_stop_s;
    logic                is_mask_s;
    logic [CH_W-1:0]     next_ch_s;
    logic                next_any_s;
    logic [CH_W-1:0]     first_ch_s;
    logic                first_any_s;

    assign is_start_s = bus.cmd_valid && (bus.cmd_word == CMD_ACQ_START);
    assign is_stop_s  = bus.cmd_valid && (bus.cmd_word == CMD_ACQ_STOP);
    assign is_mask_s  = bus.cmd_valid && (bus.cmd_word[CMD_W-1:4] == CMD_CH_MASK_HI);

    // Advance from the current channel at NEXT.
    rr_next_channel u_rr_next (
        .mask        (ch_mask_r),
        .cur_ch      (cur_ch_r),
        .next_ch     (next_ch_s),
        .any_enabled (next_any_s)
    );

    // Start pick: searching after the last channel gives the lowest enabled one.
    rr_next_channel u_rr_first (
        .mask        (ch_mask_r),
        .cur_ch      (CH_W'(NUM_CH - 1)),
        .next_ch     (first_ch_s),
        .any_enabled (first_any_s)
    );

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            ch_mask_r        <= 4'hF;
            stop_pending_r   <= 1'b0;
            cur_ch_r         <= 2'd0;
            settle_cnt_r     <= 8'd0;
            adc_chn_select_r <= 2'd0;
            adc_conv_start_r <= 1'b0;
            fifo_wr_en_r     <= 1'b0;
            fifo_din_r       <= 16'h0000;
            acq_busy_r       <= 1'b0;
            overflow_r       <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
            wait_cnt_r       <= '0;
`else
`endif
        end else begin
            // Mask updates apply immediately; a running scan sees them at NEXT.
            if (is_mask_s) begin
                ch_mask_r <= bus.cmd_word[NUM_CH-1:0];
            end
            // Stop only matters while scanning; the NEXT branch may override.
            if (is_stop_s && (state_r != ST_IDLE)) begin
                stop_pending_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (is_start_s && first_any_s) begin
                        cur_ch_r         <= first_ch_s;
                        adc_chn_select_r <= first_ch_s;
                        settle_cnt_r     <= 8'd0;
                        overflow_r       <= 1'b0;
                        acq_busy_r       <= 1'b1;
                        state_r          <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        adc_conv_start_r <= 1'b1;
                        state_r          <= ST_CONVERT;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
                    end
                end
                ST_CONVERT: begin
                    adc_conv_start_r <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
                    wait_cnt_r       <= '0;
`else
`endif
                    state_r          <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The write strobe is registered, so the full flag seen
                    // alongside the data decides whether the WRITE cycle writes.
                    if (bus.adc_data_valid) begin
                        if (bus.fifo_full) begin
                            overflow_r <= 1'b1;
                        end else begin
                            fifo_wr_en_r <= 1'b1;
                            fifo_din_r   <= pack_fifo_word(cur_ch_r, bus.adc_data);
                        end
                        state_r <= ST_WRITE;
                    end else begin
`ifdef ADC_SCAN_TIMEOUT_EN
                        if (wait_cnt_r == TO_LAST) begin
                            overflow_r <= 1'b1;
                            state_r    <= ST_NEXT;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + TO_W'(1);
                        end
`else
                        state_r <= ST_WAIT;
`endif
                    end
                end
                ST_WRITE: begin
                    fifo_wr_en_r <= 1'b0;
                    state_r      <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (stop_pending_r || !next_any_s) begin
                        // A stop arriving in this very cycle is moot: we are
                        // already heading to IDLE.
                        stop_pending_r <= 1'b0;
                        acq_busy_r     <= 1'b0;
                        state_r        <= ST_IDLE;
                    end else begin
                        cur_ch_r         <= next_ch_s;
                        adc_chn_select_r <= next_ch_s;
                        settle_cnt_r     <= 8'd0;
                        state_r          <= ST_SETTLE;
                    end
                end
                default: begin
                    adc_conv_start_r <= 1'b0;
                    fifo_wr_en_r     <= 1'b0;
                    stop_pending_r   <= 1'b0;
                    acq_busy_r       <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.adc_chn_select = adc_chn_select_r;
    assign bus.adc_conv_start = adc_conv_start_r;
    assign bus.fifo_wr_en     = fifo_wr_en_r;
    assign bus.fifo_din       = fifo_din_r;
    assign bus.acq_busy       = acq_busy_r;
    assign bus.overflow       = overflow_r;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_sequencer
// Randomized bench for adc_scan_sequencer. A small reference model (enable
// mask, expected channel, sticky overflow, pending stop) predicts the channel
// order, FIFO words and status; timing is checked with cycle arithmetic.
// ---------------------------------------------------------------------------
module tb_adc_scan_sequencer;
    import adc_scan_sequencer_pkg::*;

    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 1024;
    localparam int BUDGET  = 3000;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    adc_scan_sequencer_if bus();

    adc_scan_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] m_mask;
    logic [1:0] m_ch;
    bit         m_ovf;
    bit         m_busy;
    bit         m_stop;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Next enabled channel after cur, wrapping; cur itself if it is the only one.
    function automatic logic [1:0] m_next(input logic [3:0] mask, input logic [1:0] cur);
        int c;
        for (int k = 1; k <= 4; k++) begin
            c = (int'(cur) + k) % 4;
            if (mask[c]) return 2'(c);
        end
        return cur;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mask = 4'hF;
        m_ovf  = 1'b0;
        m_busy = 1'b0;
        m_stop = 1'b0;
    endtask

    task automatic send_cmd(input logic [15:0] w);
        bus.cmd_word  = w;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        if (w[15:4] == 12'hC00) m_mask = w[3:0];
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_sel"},  32'(bus.adc_chn_select), 32'd0);
        chk_eq({tag, "_conv"}, 32'(bus.adc_conv_start), 32'd0);
        chk_eq({tag, "_wr"},   32'(bus.fifo_wr_en),     32'd0);
        chk_eq({tag, "_din"},  32'(bus.fifo_din),       32'd0);
        chk_eq({tag, "_busy"}, 32'(bus.acq_busy),       32'd0);
        chk_eq({tag, "_ovf"},  32'(bus.overflow),       32'd0);
    endtask

    // Steps until adc_conv_start is seen; n = cycles stepped.
    task automatic wait_conv(output int n);
        int wr_seen;
        n = 0;
        wr_seen = 0;
        do begin
            step();
            n++;
            if (bus.fifo_wr_en) wr_seen++;
        end while (!bus.adc_conv_start && n < BUDGET);
        chk_eq("conv_start_seen", 32'(bus.adc_conv_start), 32'd1);
        chk_eq("no_wr_while_settling", 32'(wr_seen), 32'd0);
    endtask

    // Issue start in cycle 0; returns in cycle 1 (first SETTLE cycle).
    task automatic start_scan();
        m_ch   = m_next(m_mask, 2'd3);
        m_ovf  = 1'b0;
        m_busy = 1'b1;
        m_stop = 1'b0;
        bus.cmd_word  = 16'hF0F0;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        chk_eq("start_busy", 32'(bus.acq_busy),       32'd1);
        chk_eq("start_sel",  32'(bus.adc_chn_select), 32'(m_ch));
        chk_eq("start_ovf",  32'(bus.overflow),       32'd0);
    endtask

    // One conversion: exp_wait = cycles until conv_start, lat = cycles from
    // conv_start to data_valid (>= 2), optional command during the first WAIT cycle.
    task automatic do_sample(input int exp_wait, input int lat, input bit full,
                             input bit has_cmd, input logic [15:0] cmd);
        int n;
        logic [11:0] d;
        wait_conv(n);
        chk_eq("conv_spacing", 32'(n), 32'(exp_wait));
        chk_eq("conv_channel", 32'(bus.adc_chn_select), 32'(m_ch));
        // data_valid outside WAIT must be ignored
        bus.adc_data_valid = 1'($urandom_range(1, 0));
        bus.adc_data       = 12'($urandom);
        step();
        bus.adc_data_valid = 1'b0;
        chk_eq("conv_one_cycle", 32'(bus.adc_conv_start), 32'd0);
        if (has_cmd) begin
            bus.cmd_word  = cmd;
            bus.cmd_valid = 1'b1;
            if (cmd[15:4] == 12'hC00) m_mask = cmd[3:0];
            if (cmd == 16'hF0F1) m_stop = 1'b1;
        end
        for (int i = 1; i < lat; i++) begin
            step();
            bus.cmd_valid = 1'b0;
        end
        chk_eq("wr_before_data", 32'(bus.fifo_wr_en), 32'd0);
        d = 12'($urandom);
        bus.adc_data       = d;
        bus.adc_data_valid = 1'b1;
        bus.fifo_full      = full;
        step();
        bus.adc_data_valid = 1'b0;
        chk_eq("wr_after_valid", 32'(bus.fifo_wr_en), 32'(!full));
        if (!full) chk_eq("fifo_din", 32'(bus.fifo_din), 32'({m_ch, 2'b00, d}));
        else m_ovf = 1'b1;
        step();
        bus.fifo_full = 1'b0;
        chk_eq("wr_single_cycle", 32'(bus.fifo_wr_en), 32'd0);
        chk_eq("overflow",        32'(bus.overflow),   32'(m_ovf));
        chk_eq("busy_in_next",    32'(bus.acq_busy),   32'd1);
        if (m_stop || m_mask == 4'h0) begin
            step();
            chk_eq("busy_fall", 32'(bus.acq_busy), 32'd0);
            m_busy = 1'b0;
            m_stop = 1'b0;
        end else begin
            m_ch = m_next(m_mask, m_ch);
        end
    endtask

    initial begin
        int n;
        int convs;
        int k;
        int sel;
        bit first;
        bit has;
        logic [15:0] cmd;

        reset_n            = 1'b0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_word       = 16'h0000;
        bus.adc_data_valid = 1'b0;
        bus.adc_data       = 12'h000;
        bus.fifo_full      = 1'b0;
        model_reset();
        repeat (3) step();
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        step();

        // Full mask, ADC answers 4 cycles after conv_start: 0,1,2,3,0 then stop
        start_scan();
        do_sample(SETTLE, 4, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) do_sample(SETTLE + 1, 4, 1'b0, 1'b0, 16'h0000);
        do_sample(SETTLE + 1, 4, 1'b0, 1'b1, 16'hF0F1);
        send_cmd(16'hF0F1);
        chk_eq("stop_in_idle", 32'(bus.acq_busy), 32'd0);

        // Mask 5 -> 0,2,0; switch to mask 8 mid-scan -> 3,3
        send_cmd(16'hC005);
        start_scan();
        do_sample(SETTLE,     $urandom_range(6, 2), 1'b0, 1'b0, 16'h0000);
        do_sample(SETTLE + 1, $urandom_range(6, 2), 1'b0, 1'b0, 16'h0000);
        do_sample(SETTLE + 1, $urandom_range(6, 2), 1'b0, 1'b1, 16'hC008);
        do_sample(SETTLE + 1, $urandom_range(6, 2), 1'b0, 1'b0, 16'h0000);
        do_sample(SETTLE + 1, $urandom_range(6, 2), 1'b0, 1'b1, 16'hF0F1);

        // FIFO full for two samples: dropped, overflow sticky, scanning continues
        send_cmd(16'hC00F);
        start_scan();
        do_sample(SETTLE,     3, 1'b0, 1'b0, 16'h0000);
        do_sample(SETTLE + 1, 3, 1'b1, 1'b0, 16'h0000);
        do_sample(SETTLE + 1, 3, 1'b1, 1'b1, 16'hF0F0);
        do_sample(SETTLE + 1, 3, 1'b0, 1'b1, 16'hF0F1);
        chk_eq("ovf_sticky_idle", 32'(bus.overflow), 32'd1);
        start_scan();
        do_sample(SETTLE, 2, 1'b0, 1'b1, 16'hF0F1);

        // Randomized rounds: random masks, FIFO full, in-flight commands
        for (int r = 0; r < 8; r++) begin
            send_cmd(16'hC000 | 16'($urandom_range(15, 1)));
            start_scan();
            first = 1'b1;
            k = $urandom_range(6, 2);
            for (int s = 0; s < k && m_busy; s++) begin
                has = 1'b1;
                if (s == k - 1) begin
                    cmd = 16'hF0F1;
                end else begin
                    sel = $urandom_range(5, 0);
                    case (sel)
                        0: cmd = 16'hF0F0;
                        1: cmd = 16'hC000 | 16'($urandom_range(15, 0));
                        2: cmd = 16'hC01A;
                        default: begin
                            cmd = 16'h0000;
                            has = 1'b0;
                        end
                    endcase
                end
                do_sample(first ? SETTLE : SETTLE + 1, $urandom_range(6, 2),
                          ($urandom_range(3, 0) == 0), has, cmd);
                first = 1'b0;
            end
            send_cmd(16'hF0F1);
        end

        // Start with an empty mask is ignored
        send_cmd(16'hC000);
        send_cmd(16'hF0F0);
        convs = 0;
        for (int i = 0; i < 4; i++) begin
            chk_eq("mask0_busy", 32'(bus.acq_busy), 32'd0);
            if (bus.adc_conv_start) convs++;
            step();
        end
        chk_eq("mask0_no_conv", 32'(convs), 32'd0);

        // Suppressed adc_data_valid
        send_cmd(16'hC00F);
        start_scan();
        wait_conv(n);
        chk_eq("hang_first_conv", 32'(n), 32'(SETTLE));
`ifdef ADC_SCAN_TIMEOUT_EN
        wait_conv(n);
        chk_eq("timeout_spacing", 32'(n), 32'(TIMEOUT + SETTLE + 2));
        chk_eq("timeout_ovf",     32'(bus.overflow),       32'd1);
        chk_eq("timeout_next_ch", 32'(bus.adc_chn_select), 32'd1);
`else
        convs = 0;
        repeat (1100) begin
            step();
            if (bus.adc_conv_start) convs++;
        end
        chk_eq("hang_busy",    32'(bus.acq_busy), 32'd1);
        chk_eq("hang_no_conv", 32'(convs),        32'd0);
        chk_eq("hang_ovf",     32'(bus.overflow), 32'd0);
`endif
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_wait");
        model_reset();
        step();
        reset_n = 1'b1;
        step();

        // Reset during SETTLE restores outputs and the full channel mask
        send_cmd(16'hC002);
        start_scan();
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_settle");
        model_reset();
        step();
        reset_n = 1'b1;
        step();
        start_scan();
        do_sample(SETTLE, 3, 1'b0, 1'b1, 16'hF0F1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
